// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage types: ALU control codes and the multiply sequencer state set.
package mips_pkg;

  typedef logic [3:0] alu_ctrl_t;

  localparam alu_ctrl_t ALU_AND = 4'b0000;
  localparam alu_ctrl_t ALU_OR  = 4'b0001;
  localparam alu_ctrl_t ALU_ADD = 4'b0010;
  localparam alu_ctrl_t ALU_SUB = 4'b0110;
  localparam alu_ctrl_t ALU_SLT = 4'b0111;
  localparam alu_ctrl_t ALU_NOR = 4'b1100;
  localparam alu_ctrl_t ALU_SLL = 4'b1111;
  localparam alu_ctrl_t ALU_SRL = 4'b1110;

  typedef enum logic [2:0] {
    IDLE, NEG_A, NEG_B, MUL, FIX_LO, FIX_HI, DONE
  } mul_state_t;

  localparam int MUL_ITERS = 32;

endpackage

// File: rtl/alu.sv
// 32-bit combinational execute-stage ALU shared with the multiply sequencer.
module alu
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_ctrl_t   ctrl,
  output logic [31:0] result,
  output logic        zeroFlag
);

  always_comb begin
    result = '0;
    case (ctrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {31'b0, $signed(a) < $signed(b)};
      ALU_NOR: result = ~(a | b);
      ALU_SLL: result = a << b[4:0];
      ALU_SRL: result = a >> b[4:0];
      default: result = '0;
    endcase
  end

  assign zeroFlag = (result == '0);

endmodule

// File: rtl/mul_sequencer.sv
// MULT/MULTU controller: sign-correct operands, 32 shift-add steps through the shared ALU,
// then sign-correct the 64-bit product. Fixed 36-cycle busy window, one-cycle done.
module mul_sequencer
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mul_state_t       state, state_n;
  logic [WIDTH-1:0] a_r, b_r, mcand;
  logic             sgn_r, neg_r, lo_zero;
  logic [4:0]       cnt;
  logic             neg_a, neg_b, carry;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  alu_ctrl_t        alu_op;

  assign neg_a = sgn_r & a_r[WIDTH-1];
  assign neg_b = sgn_r & b_r[WIDTH-1];
  // carry out of hi + addend, recovered without a 33-bit adder
  assign carry = (alu_y < hi);

  alu u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .ctrl     (alu_op),
    .result   (alu_y),
    .zeroFlag ()
  );

  always_comb begin
    state_n = state;
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = ALU_ADD;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE:   if (start) state_n = NEG_A;
      NEG_A: begin
        busy    = 1'b1;
        alu_a   = neg_a ? '0 : a_r;
        alu_b   = neg_a ? a_r : '0;
        alu_op  = neg_a ? ALU_SUB : ALU_ADD;
        state_n = NEG_B;
      end
      NEG_B: begin
        busy    = 1'b1;
        alu_a   = neg_b ? '0 : b_r;
        alu_b   = neg_b ? b_r : '0;
        alu_op  = neg_b ? ALU_SUB : ALU_ADD;
        state_n = MUL;
      end
      MUL: begin
        busy  = 1'b1;
        alu_a = hi;
        alu_b = lo[0] ? mcand : '0;
        if (cnt == 5'(MUL_ITERS - 1)) state_n = FIX_LO;
      end
      FIX_LO: begin
        busy    = 1'b1;
        alu_a   = neg_r ? '0 : lo;
        alu_b   = neg_r ? lo : '0;
        alu_op  = neg_r ? ALU_SUB : ALU_ADD;
        state_n = FIX_HI;
      end
      FIX_HI: begin
        // high word of a 64-bit negate: ~hi plus the borrow-free case of a zero low word
        busy    = 1'b1;
        alu_a   = neg_r ? ~hi : hi;
        alu_b   = neg_r ? {{(WIDTH-1){1'b0}}, lo_zero} : '0;
        state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      mcand   <= '0;
      sgn_r   <= 1'b0;
      neg_r   <= 1'b0;
      lo_zero <= 1'b0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          a_r   <= op_a;
          b_r   <= op_b;
          sgn_r <= is_signed;
          neg_r <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          hi    <= '0;
        end
        NEG_A:  mcand <= alu_y;
        NEG_B: begin
          lo  <= alu_y;
          cnt <= '0;
        end
        MUL: begin
          hi  <= {carry, alu_y[WIDTH-1:1]};
          lo  <= {alu_y[0], lo[WIDTH-1:1]};
          cnt <= cnt + 5'd1;
        end
        FIX_LO: begin
          lo      <= alu_y;
          lo_zero <= (lo == '0);
        end
        FIX_HI:  hi <= alu_y;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Randomized and directed checks of mul_sequencer against a 64-bit arithmetic product model.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, is_signed;
  logic [31:0] op_a, op_b, hi, lo;
  logic        busy, done;

  int checks   = 0;
  int failures = 0;

  mul_sequencer #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input bit s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb;
    xa = s ? {{32{a[31]}}, a} : {32'h0, a};
    xb = s ? {{32{b[31]}}, b} : {32'h0, b};
    return xa * xb;
  endfunction

  // Drive a request for one edge; returns #1 after the accepting edge.
  task automatic start_op(input bit s, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; is_signed = s; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; op_a = $urandom; op_b = $urandom; is_signed = $urandom_range(0, 1);
  endtask

  // Samples #1 after each edge from the accept edge on; k is the edge index after acceptance.
  task automatic wait_done(input bit intrude, output int k_done, output int busy_n);
    k_done = -1;
    busy_n = 0;
    for (int k = 0; k < 60; k++) begin
      if (busy) busy_n++;
      if (intrude && (k == 5 || k == 36)) begin
        start = 1'b1; is_signed = 1'b0; op_a = 32'd7; op_b = 32'd9;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        k_done = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_check(input string tag, input bit s, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input bit intrude);
    int kd, bn;
    start_op(s, a, b);
    wait_done(intrude, kd, bn);
    chk({tag, "_lat"}, 64'(kd), 64'd36);
    chk({tag, "_busy"}, 64'(bn), 64'd36);
    chk({tag, "_prod"}, {hi, lo}, exp);
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_post"}, {62'b0, busy, done}, 64'd0);
  endtask

  initial begin
    int kd, bn, dcount, bad_lat, bad_busy, bad_prod;
    logic [31:0] ra, rb;
    bit rs;

    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", {busy, done, hi, lo}, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_check("multu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    run_check("mult_m3x5", 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
    run_check("mult_m3xm5", 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 64'h0000_0000_0000_000F, 1'b0);
    run_check("mult_min2", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
    run_check("mult_m7x0", 1'b1, 32'hFFFF_FFF9, 32'h0000_0000, 64'h0, 1'b0);
    run_check("multu_min", 1'b0, 32'h8000_0000, 32'h0000_0003, 64'h0000_0001_8000_0000, 1'b0);

    // 7x9 pulses mid-operation and in the done cycle must not be taken
    run_check("ignore_2x3", 1'b0, 32'd2, 32'd3, 64'd6, 1'b1);
    run_check("after_9x7", 1'b0, 32'd7, 32'd9, 64'd63, 1'b0);

    // Reset aborts an operation in flight
    start_op(1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (20) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_state", {busy, done, hi, lo}, '0);
    dcount = 0;
    repeat (50) begin @(posedge clk); #1; if (done || busy) dcount++; end
    chk("abort_nodone", 64'(dcount), 64'd0);
    run_check("after_abort", 1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);

    // Random back-to-back traffic: aggregate per-property error counts into single checks
    bad_lat = 0; bad_busy = 0; bad_prod = 0;
    for (int i = 0; i < 1000; i++) begin
      rs = $urandom_range(0, 1);
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 7))
        0: ra = 32'h8000_0000;
        1: rb = 32'h0;
        2: ra = 32'hFFFF_FFFF;
        default: ;
      endcase
      start_op(rs, ra, rb);
      wait_done(1'b0, kd, bn);
      if (kd != 36) bad_lat++;
      if (bn != 36) bad_busy++;
      if ({hi, lo} !== ref_prod(rs, ra, rb)) begin
        bad_prod++;
        if (bad_prod <= 5)
          chk("rand_prod", {hi, lo}, ref_prod(rs, ra, rb));
      end
      @(posedge clk); #1;
      if (done) bad_lat++;
    end
    chk("rand_lat_errs", 64'(bad_lat), 64'd0);
    chk("rand_busy_errs", 64'(bad_busy), 64'd0);
    chk("rand_prod_errs", 64'(bad_prod), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
